// File: rtl/huffman_enc_packer_if.sv
// Stream bundle for the Huffman encoder: code-table load port, symbol input and packed-word output.
// The slave modport is the encoder's view; the master modport is the surrounding system's view.
interface huffman_enc_packer_if #(
    parameter int SYM_W = 8,
    parameter int OUT_W = 128,
    parameter int TAB_W = 64
) ();
    localparam int BITS_W = $clog2(OUT_W) + 1;

    logic [TAB_W-1:0]  s_tab_tdata;
    logic              s_tab_tvalid;
    logic              s_tab_tready;
    logic [SYM_W-1:0]  s_sym_tdata;
    logic              s_sym_tvalid;
    logic              s_sym_tlast;
    logic              s_sym_tready;
    logic [OUT_W-1:0]  m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic [BITS_W-1:0] m_tbits;
    logic              m_tready;

    modport slave (
        input  s_tab_tdata, s_tab_tvalid,
        output s_tab_tready,
        input  s_sym_tdata, s_sym_tvalid, s_sym_tlast,
        output s_sym_tready,
        output m_tdata, m_tvalid, m_tlast, m_tbits,
        input  m_tready
    );

    modport master (
        output s_tab_tdata, s_tab_tvalid,
        input  s_tab_tready,
        output s_sym_tdata, s_sym_tvalid, s_sym_tlast,
        input  s_sym_tready,
        input  m_tdata, m_tvalid, m_tlast, m_tbits,
        output m_tready
    );
endinterface

// File: rtl/huffman_enc_packer.sv
// Huffman encoder core: loads a code table, maps symbols to codes and packs them MSB-first.
// Define HUFF_ENC_BITCNT_EN to add the m_pkt_bits per-packet code-bit counter output.
module huffman_enc_packer #(
    parameter int SYM_W        = 8,
    parameter int MAX_CODE_LEN = 32,
    parameter int OUT_W        = 128,
    parameter int TAB_W        = 64
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic                 we,
    huffman_enc_packer_if.slave  bus,
    output logic                 table_ready,
    output logic                 len_err
`ifdef HUFF_ENC_BITCNT_EN
    ,
    output logic [31:0]          m_pkt_bits
`endif
);
    localparam int ACC_W  = OUT_W + MAX_CODE_LEN;
    localparam int CNT_W  = $clog2(ACC_W + 1);
    localparam int BITS_W = $clog2(OUT_W) + 1;
    localparam int ENT_W  = 8 + MAX_CODE_LEN;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ENCODE, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [SYM_W-1:0]   addr_q, addr_d;
    logic               table_ready_q, table_ready_d;
    logic               len_err_q, len_err_d;
    logic               v1_q, v1_d, last1_q, last1_d, pend_last_q, pend_last_d;
    logic [ENT_W-1:0]   ent_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d, tlast_q, tlast_d;
    logic [BITS_W-1:0]  tbits_q, tbits_d;
    logic [ENT_W-1:0]   mem [1 << SYM_W];

    logic               tab_hs_s, out_free_s, emit_full_s, adv_s, sym_rdy_s, sym_hs_s;
    logic               final_s, resid_s, emit_last_s, len_bad_s;
    logic [7:0]         len_raw_s, len_clamp_s;
    logic [CNT_W-1:0]   len_s, add_len_s, base_cnt_s;
    logic [ACC_W-1:0]   code_al_s, base_acc_s;

    // Handshake qualifiers, code lookup decode and accumulator shift base
    always_comb begin
        tab_hs_s    = (state_q == S_LOAD) & bus.s_tab_tvalid;
        out_free_s  = ~tvalid_q | bus.m_tready;
        emit_full_s = out_free_s & (cnt_q >= CNT_W'(OUT_W));
        adv_s       = v1_q & ((cnt_q < CNT_W'(OUT_W)) | emit_full_s);
        sym_rdy_s   = (state_q == S_ENCODE) & (~v1_q | adv_s) & (cnt_q < CNT_W'(OUT_W));
        sym_hs_s    = sym_rdy_s & bus.s_sym_tvalid;
        len_raw_s   = ent_q[ENT_W-1 -: 8];
        len_bad_s   = (len_raw_s == 8'd0) | (len_raw_s > 8'(MAX_CODE_LEN));
        len_clamp_s = (len_raw_s > 8'(MAX_CODE_LEN)) ? 8'(MAX_CODE_LEN) : len_raw_s;
        len_s       = CNT_W'(len_clamp_s);
        add_len_s   = adv_s ? len_s : {CNT_W{1'b0}};
        // Mask the code to its length, then left-align it in the accumulator
        code_al_s   = (ACC_W'(ent_q[MAX_CODE_LEN-1:0]) & ((ACC_W'(1) << len_s) - ACC_W'(1)))
                      << (CNT_W'(ACC_W) - len_s);
        final_s     = pend_last_q | (adv_s & last1_q);
        resid_s     = out_free_s & pend_last_q & (cnt_q < CNT_W'(OUT_W));
        emit_last_s = resid_s | (emit_full_s & final_s &
                      (({1'b0, cnt_q} + {1'b0, add_len_s}) == (CNT_W + 1)'(OUT_W)));
        if (emit_full_s) begin
            base_acc_s = acc_q << OUT_W;
            base_cnt_s = cnt_q - CNT_W'(OUT_W);
        end else if (resid_s) begin
            base_acc_s = {ACC_W{1'b0}};
            base_cnt_s = {CNT_W{1'b0}};
        end else begin
            base_acc_s = acc_q;
            base_cnt_s = cnt_q;
        end
    end

    // Next-state: FSM, table address, lookup stage, accumulator and output register
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        table_ready_d = table_ready_q;
        len_err_d     = len_err_q | (adv_s & len_bad_s);
        v1_d          = v1_q;
        last1_d       = last1_q;
        pend_last_d   = pend_last_q;
        acc_d         = adv_s ? (base_acc_s | (code_al_s >> base_cnt_s)) : base_acc_s;
        cnt_d         = base_cnt_s + add_len_s;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tbits_d       = tbits_q;
        case (state_q)
            S_IDLE: begin
                if (start & we) begin
                    state_d       = S_LOAD;
                    addr_d        = {SYM_W{1'b0}};
                    table_ready_d = 1'b0;
                end else if (start & table_ready_q) begin
                    state_d = S_ENCODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (tab_hs_s) begin
                    addr_d = addr_q + SYM_W'(1);
                    if (addr_q == {SYM_W{1'b1}}) begin
                        state_d       = S_IDLE;
                        table_ready_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_ENCODE: begin
                if (sym_hs_s & bus.s_sym_tlast) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_ENCODE;
                end
            end
            S_FLUSH: begin
                if (tvalid_q & bus.m_tready & tlast_q) begin
                    state_d = S_ENCODE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (sym_hs_s) begin
            v1_d    = 1'b1;
            last1_d = bus.s_sym_tlast;
        end else if (adv_s) begin
            v1_d    = 1'b0;
            last1_d = 1'b0;
        end else begin
            v1_d    = v1_q;
        end
        if (adv_s & last1_q) begin
            pend_last_d = 1'b1;
        end else begin
            pend_last_d = pend_last_q;
        end
        if (emit_full_s | resid_s) begin
            tdata_d     = acc_q[ACC_W-1 -: OUT_W];
            tvalid_d    = 1'b1;
            tbits_d     = emit_full_s ? BITS_W'(OUT_W) : BITS_W'(cnt_q);
            tlast_d     = emit_last_s;
            pend_last_d = emit_last_s ? 1'b0 : pend_last_d;
        end else if (tvalid_q & bus.m_tready) begin
            tdata_d  = {OUT_W{1'b0}};
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tbits_d  = {BITS_W{1'b0}};
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            addr_q        <= {SYM_W{1'b0}};
            table_ready_q <= 1'b0;
            len_err_q     <= 1'b0;
            v1_q          <= 1'b0;
            last1_q       <= 1'b0;
            pend_last_q   <= 1'b0;
            acc_q         <= {ACC_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            tdata_q       <= {OUT_W{1'b0}};
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tbits_q       <= {BITS_W{1'b0}};
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            table_ready_q <= table_ready_d;
            len_err_q     <= len_err_d;
            v1_q          <= v1_d;
            last1_q       <= last1_d;
            pend_last_q   <= pend_last_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tbits_q       <= tbits_d;
        end
    end

    // Code table RAM; contents survive reset, read port is registered
    always_ff @(posedge aclk) begin
        if (tab_hs_s) begin
            mem[addr_q] <= {bus.s_tab_tdata[TAB_W-1 -: 8], bus.s_tab_tdata[MAX_CODE_LEN-1:0]};
        end
        if (sym_hs_s) begin
            ent_q <= mem[bus.s_sym_tdata];
        end
    end

`ifdef HUFF_ENC_BITCNT_EN
    logic [31:0] pkt_bits_q, pkt_bits_d;
    logic [32:0] pkt_sum_s;

    // Saturating per-packet code-bit total, cleared once the tlast word is taken
    always_comb begin
        pkt_sum_s = {1'b0, pkt_bits_q} + 33'(add_len_s);
        if (tvalid_q & bus.m_tready & tlast_q) begin
            pkt_bits_d = 32'd0;
        end else if (pkt_sum_s[32]) begin
            pkt_bits_d = 32'hFFFF_FFFF;
        end else begin
            pkt_bits_d = pkt_sum_s[31:0];
        end
    end

    // Packet bit counter register
    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_bits_q <= 32'd0;
        end else begin
            pkt_bits_q <= pkt_bits_d;
        end
    end

    assign m_pkt_bits = pkt_bits_q;
`endif

    assign bus.s_tab_tready = (state_q == S_LOAD);
    assign bus.s_sym_tready = sym_rdy_s;
    assign bus.m_tdata      = tdata_q;
    assign bus.m_tvalid     = tvalid_q;
    assign bus.m_tlast      = tlast_q;
    assign bus.m_tbits      = tbits_q;
    assign table_ready      = table_ready_q;
    assign len_err          = len_err_q;
endmodule

// File: tb/tb_huffman_enc_packer.sv
// Scoreboard bench for huffman_enc_packer: directed packets, expected words queued at issue time.
module tb_huffman_enc_packer;
    localparam int SYM_W = 8;
    localparam int MAXL  = 32;
    localparam int OUT_W = 128;
    localparam int TAB_W = 64;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   bits;
        logic         last;
        logic [31:0]  pkt;
    } exp_t;

    logic aclk = 1'b0;
    logic areset, start, we, table_ready, len_err;
    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_sent = 0;
    logic [127:0] prev_data;
    logic         prev_last;
    logic         prev_stall = 1'b0;

    huffman_enc_packer_if #(.SYM_W(SYM_W), .OUT_W(OUT_W), .TAB_W(TAB_W)) bus ();

`ifdef HUFF_ENC_BITCNT_EN
    logic [31:0] m_pkt_bits;
`endif

    huffman_enc_packer #(.SYM_W(SYM_W), .MAX_CODE_LEN(MAXL), .OUT_W(OUT_W), .TAB_W(TAB_W)) dut (
        .aclk(aclk), .areset(areset), .start(start), .we(we), .bus(bus),
        .table_ready(table_ready), .len_err(len_err)
`ifdef HUFF_ENC_BITCNT_EN
        , .m_pkt_bits(m_pkt_bits)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability
    always @(negedge aclk) begin
        if (prev_stall) begin
            chk("stall_valid", {127'd0, bus.m_tvalid}, 128'd1);
            chk("stall_data", bus.m_tdata, prev_data);
            chk("stall_last", {127'd0, bus.m_tlast}, {127'd0, prev_last});
        end
        prev_stall = bus.m_tvalid & ~bus.m_tready;
        prev_data  = bus.m_tdata;
        prev_last  = bus.m_tlast;
        if (bus.m_tvalid & bus.m_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %h with no word required", bus.m_tdata);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", bus.m_tdata, e.data);
                chk("word_bits", {120'd0, bus.m_tbits}, {120'd0, e.bits});
                chk("word_last", {127'd0, bus.m_tlast}, {127'd0, e.last});
`ifdef HUFF_ENC_BITCNT_EN
                if (e.last) chk("pkt_bits", {96'd0, m_pkt_bits}, {96'd0, e.pkt});
`endif
            end
        end
    end

    function automatic logic [63:0] entry(input int kind, input int i);
        logic [7:0]  len;
        logic [31:0] code;
        len  = 8'd8;
        code = 32'(i);
        if (kind == 1) begin
            len  = 8'd1;
            code = 32'(i & 1);
        end
        if (kind == 2 && i == 7) len = 8'd0;
        return {len, 24'd0, code};
    endfunction

    task automatic push(input logic [127:0] d, input int bits, input bit last, input int pkt);
        exp_t x;
        x.data = d; x.bits = 8'(bits); x.last = last; x.pkt = 32'(pkt);
        exp_q.push_back(x);
    endtask

    task automatic wait_hs(input bit is_tab, input string name);
        for (int t = 0; t < 300; t++) begin
            @(negedge aclk);
            if (is_tab ? bus.s_tab_tready : bus.s_sym_tready) begin
                @(posedge aclk);
                #1;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake timeout, ready 0 required 1", name);
    endtask

    task automatic do_reset();
        areset = 1'b1; start = 1'b0; we = 1'b0;
        bus.s_tab_tvalid = 1'b0; bus.s_sym_tvalid = 1'b0; bus.s_sym_tlast = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic pulse_start(input bit w);
        start = 1'b1; we = w;
        @(posedge aclk);
        #1 start = 1'b0; we = 1'b0;
    endtask

    task automatic load_table(input int kind, input int n);
        pulse_start(1'b1);
        for (int i = 0; i < n; i++) begin
            bus.s_tab_tdata  = entry(kind, i);
            bus.s_tab_tvalid = 1'b1;
            wait_hs(1'b1, "tab_hs");
        end
        bus.s_tab_tvalid = 1'b0;
    endtask

    task automatic send_sym(input logic [7:0] s, input bit last);
        bus.s_sym_tdata = s; bus.s_sym_tlast = last; bus.s_sym_tvalid = 1'b1;
        wait_hs(1'b0, "sym_hs");
        bus.s_sym_tvalid = 1'b0; bus.s_sym_tlast = 1'b0;
        n_sent++;
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 1000; t++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && !bus.m_tvalid) begin
                @(posedge aclk);
                #1;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: drain timeout, %0d words still required", name, exp_q.size());
    endtask

    initial begin
        logic [127:0] w;
        logic [127:0] aa;
        int seen;
        bus.m_tready = 1'b1;
        bus.s_tab_tdata = 64'd0; bus.s_sym_tdata = 8'd0;
        do_reset();
        chk("rst_tab_tready", {127'd0, bus.s_tab_tready}, 128'd0);
        chk("rst_sym_tready", {127'd0, bus.s_sym_tready}, 128'd0);
        chk("rst_m_tvalid", {127'd0, bus.m_tvalid}, 128'd0);
        chk("rst_m_tdata", bus.m_tdata, 128'd0);
        chk("rst_m_tlast_bits", {119'd0, bus.m_tlast, bus.m_tbits}, 128'd0);
        chk("rst_flags", {126'd0, table_ready, len_err}, 128'd0);

        // Identity table, 8-bit codes
        load_table(0, 256);
        chk("table_ready_a", {127'd0, table_ready}, 128'd1);
        pulse_start(1'b0);
        push(128'h000102030405060708090A0B0C0D0E0F, 128, 1'b1, 128);
        for (int i = 0; i < 16; i++) send_sym(8'(i), i == 15);
        wait_drain("t1");
        push(128'hA55AFF << 104, 24, 1'b1, 24);
        send_sym(8'hA5, 1'b0); send_sym(8'h5A, 1'b0); send_sym(8'hFF, 1'b1);
        wait_drain("t2");

        // Output stall with 48 symbols spanning three words
        for (int k = 0; k < 3; k++) begin
            w = 128'd0;
            for (int j = 0; j < 16; j++) w = {w[119:0], 8'(16 * k + j)};
            push(w, 128, k == 2, 384);
        end
        n_sent = 0;
        fork
            begin
                for (int i = 0; i < 48; i++) send_sym(8'(i), i == 47);
            end
            begin
                bus.m_tready = 1'b0;
                repeat (45) @(posedge aclk);
                @(negedge aclk);
                chk("stall_sym_tready", {127'd0, bus.s_sym_tready}, 128'd0);
                chk("stall_backpressure", {127'd0, n_sent < 48}, 128'd1);
                @(posedge aclk);
                #1 bus.m_tready = 1'b1;
            end
        join
        wait_drain("t4");

        // One-bit codes, 300 alternating symbols
        do_reset();
        load_table(1, 256);
        pulse_start(1'b0);
        aa = {32{4'hA}};
        push(aa, 128, 1'b0, 300);
        push(aa, 128, 1'b0, 300);
        push(aa & ~((128'd1 << 84) - 128'd1), 44, 1'b1, 300);
        for (int i = 0; i < 300; i++) send_sym(8'((i % 2 == 0) ? 1 : 0), i == 299);
        wait_drain("t3");

        // Zero-length entry sets len_err
        do_reset();
        load_table(2, 256);
        pulse_start(1'b0);
        push(128'h01 << 120, 8, 1'b1, 8);
        send_sym(8'h07, 1'b0); send_sym(8'h01, 1'b1);
        wait_drain("t5");
        chk("len_err_set", {127'd0, len_err}, 128'd1);
        push(128'h02 << 120, 8, 1'b1, 8);
        send_sym(8'h02, 1'b1);
        wait_drain("t5b");
        chk("len_err_sticky", {127'd0, len_err}, 128'd1);
        do_reset();
        chk("len_err_cleared", {127'd0, len_err}, 128'd0);

        // Reset during a partial load
        load_table(0, 100);
        do_reset();
        chk("partial_table_ready", {127'd0, table_ready}, 128'd0);
        pulse_start(1'b0);
        seen = 0;
        bus.s_sym_tdata = 8'h01; bus.s_sym_tlast = 1'b1; bus.s_sym_tvalid = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            if (bus.s_sym_tready || bus.s_tab_tready) seen++;
        end
        @(posedge aclk);
        #1 bus.s_sym_tvalid = 1'b0; bus.s_sym_tlast = 1'b0;
        chk("idle_ignores_encode", 128'(seen), 128'd0);
        load_table(0, 256);
        chk("table_ready_reload", {127'd0, table_ready}, 128'd1);
        pulse_start(1'b0);
        push(128'h3C << 120, 8, 1'b1, 8);
        send_sym(8'h3C, 1'b1);
        wait_drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
